// File: rtl/mod_phase_sequencer.sv
// Multi-phase capture sequencer: drains, settles and exposes each sub-frame, then hands it to readout.
// BUSY follows START by one edge; READOUT_REQ is held until READOUT_ACK; ABORT returns to IDLE in one edge.
module mod_phase_sequencer #(
  parameter int EXP_W         = 16,
  parameter int DRAIN_CYCLES  = 64,
  parameter int SETTLE_CYCLES = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             i_user_clock,
  input  logic             i_reset_b,
  input  logic             i_start,
  input  logic             i_abort,
  input  logic [2:0]       i_num_phases,
  input  logic [4:0]       i_phase_start,
  input  logic [4:0]       i_phase_step,
  input  logic [3:0]       i_duty_cfg,
  input  logic [EXP_W-1:0] i_exposure_cycles,
  input  logic             i_mod_sig_and,
  input  logic             i_readout_ack,
  output logic [4:0]       o_phase_sel,
  output logic [3:0]       o_duty_sel,
  output logic             o_drain_b,
  output logic             o_readout_req,
  output logic [2:0]       o_phase_idx,
  output logic             o_busy,
  output logic             o_frame_done
);

  localparam int CNT_MAX = (DRAIN_CYCLES > SETTLE_CYCLES) ? DRAIN_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DRAIN   = 3'd1,
    S_SETTLE  = 3'd2,
    S_EXPOSE  = 3'd3,
    S_READOUT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [EXP_W-1:0]       r_edge_cnt;
  logic [EXP_W-1:0]       r_exposure;
  logic [2:0]             r_num_phases;
  logic [2:0]             r_phase_idx;
  logic [4:0]             r_phase_step;
  logic [4:0]             r_phase_sel;
  logic [3:0]             r_duty_sel;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_prev;

  logic [EXP_W-1:0]       w_edge_cnt_inc;
  logic                   w_sync;
  logic                   w_edge;
  logic                   w_exp_hit;
  logic                   w_last_phase;

  assign w_sync         = r_sync[SYNC_STAGES-1];
  assign w_edge         = w_sync & ~r_sync_prev;
  assign w_edge_cnt_inc = r_edge_cnt + EXP_W'(1);
  assign w_exp_hit      = w_edge && (w_edge_cnt_inc == r_exposure);
  assign w_last_phase   = (r_phase_idx == r_num_phases);

  assign o_phase_sel   = r_phase_sel;
  assign o_duty_sel    = r_duty_sel;
  assign o_phase_idx   = r_phase_idx;
  assign o_busy        = (r_state != S_IDLE);
  assign o_drain_b     = (r_state == S_EXPOSE) || (r_state == S_READOUT);
  assign o_readout_req = (r_state == S_READOUT);
  assign o_frame_done  = (r_state == S_DONE);

  always_ff @(posedge i_user_clock or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (i_start) w_state_nxt = S_DRAIN;
        S_DRAIN:   if (r_cnt == DRAIN_LAST) w_state_nxt = S_SETTLE;
        S_SETTLE:  if (r_cnt == SETTLE_LAST) w_state_nxt = S_EXPOSE;
        S_EXPOSE:  if (w_exp_hit) w_state_nxt = S_READOUT;
        S_READOUT: if (i_readout_ack) w_state_nxt = w_last_phase ? S_DONE : S_DRAIN;
        S_DONE:    w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // The synchroniser runs in every state so EXPOSE starts with a settled edge history.
  always_ff @(posedge i_user_clock or negedge i_reset_b) begin
    if (!i_reset_b) begin
      r_cnt        <= '0;
      r_edge_cnt   <= '0;
      r_exposure   <= '0;
      r_num_phases <= '0;
      r_phase_idx  <= '0;
      r_phase_step <= '0;
      r_phase_sel  <= '0;
      r_duty_sel   <= '0;
      r_sync       <= '0;
      r_sync_prev  <= 1'b0;
    end else begin
      r_sync      <= {r_sync[SYNC_STAGES-2:0], i_mod_sig_and};
      r_sync_prev <= w_sync;
      if (!i_abort) begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_num_phases <= i_num_phases;
              r_phase_step <= i_phase_step;
              r_duty_sel   <= i_duty_cfg;
              r_exposure   <= (i_exposure_cycles == '0) ? EXP_W'(1) : i_exposure_cycles;
              r_phase_sel  <= i_phase_start;
              r_phase_idx  <= '0;
              r_cnt        <= '0;
            end
          end
          S_DRAIN: begin
            r_cnt <= (r_cnt == DRAIN_LAST) ? '0 : r_cnt + CNT_W'(1);
          end
          S_SETTLE: begin
            r_cnt      <= (r_cnt == SETTLE_LAST) ? '0 : r_cnt + CNT_W'(1);
            r_edge_cnt <= '0;
          end
          S_EXPOSE: begin
            if (w_edge) r_edge_cnt <= w_edge_cnt_inc;
          end
          S_READOUT: begin
            if (i_readout_ack && !w_last_phase) begin
              r_phase_idx <= r_phase_idx + 3'd1;
              r_phase_sel <= r_phase_sel + r_phase_step;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
